// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch stage for the MIPS core.
// Holds the PC, a synchronous-read instruction memory and a small instruction
// queue. Decode receives {instr, instr_pc} over a valid/ready handshake.
// Branch/jump redirects reload the PC. A misaligned target puts the unit into
// a sticky FAULT state, and only reset clears it.
// Optional feature: define MIPS_FETCH_PERF_EN to add the perf_fetched and
// perf_bubbles counters.
module mips_fetch_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int IMEM_DEPTH  = 256,
    parameter int QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          redirect,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [DATA_WIDTH-1:0]         instr,
    output logic [ADDR_WIDTH-1:0]         instr_pc,
    output logic                          fetch_fault,
`ifdef MIPS_FETCH_PERF_EN
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_bubbles,
`endif
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [DATA_WIDTH-1:0]         imem_wdata
);

    localparam int IW   = $clog2(IMEM_DEPTH);
    localparam int QW   = $clog2(QUEUE_DEPTH);
    localparam int CNTW = QW + 1;
    localparam int OCCW = QW + 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic [QW-1:0]          head_q, head_d;
    logic [QW-1:0]          tail_q, tail_d;
    logic                   fault_q, fault_d;

    logic [DATA_WIDTH-1:0]  imem_mem [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0]  imem_rdata_q;
    logic [DATA_WIDTH-1:0]  queue_instr_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  queue_pc_q [QUEUE_DEPTH];

    logic                   head_valid;
    logic                   pop;
    logic                   flush;
    logic                   misaligned;
    logic                   issue;
    logic                   enqueue;
    logic [OCCW-1:0]        occupancy;

    // Handshake, issue decision and next-state for the PC, queue pointers and FSM
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        fault_d       = fault_q;

        head_valid = (state_q == ST_RUN) && (count_q != '0);
        pop        = head_valid && instr_ready;
        misaligned = redirect_pc[1:0] != 2'b00;
        flush      = (state_q == ST_RUN) && redirect;
        // Slots in use once this cycle's pop leaves. This lets a full queue keep
        // streaming at one instruction per cycle.
        occupancy  = OCCW'(count_q) + OCCW'(inflight_q) - OCCW'(pop);
        issue      = (state_q == ST_RUN) && !redirect && (occupancy < OCCW'(QUEUE_DEPTH));
        enqueue    = inflight_q && !flush;

        if (flush) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            inflight_d = 1'b0;
            if (misaligned) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                pc_d = redirect_pc;
            end
        end else begin
            head_d     = head_q + QW'(pop);
            tail_d     = tail_q + QW'(enqueue);
            count_d    = count_q + CNTW'(enqueue) - CNTW'(pop);
            inflight_d = issue;
            if (issue) begin
                pc_d          = pc_q + ADDR_WIDTH'(4);
                inflight_pc_d = pc_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_VECTOR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            fault_q       <= fault_d;
        end
    end

    // IMEM: load-port write plus registered read. A same-index collision returns the old word.
    always_ff @(posedge CLK) begin
        if (imem_we) begin
            imem_mem[imem_waddr] <= imem_wdata;
        end
        if (issue) begin
            imem_rdata_q <= imem_mem[pc_q[2 +: IW]];
        end
    end

    // Queue storage: the returning read lands at the tail together with its PC
    always_ff @(posedge CLK) begin
        if (enqueue) begin
            queue_instr_q[tail_q] <= imem_rdata_q;
            queue_pc_q[tail_q]    <= inflight_pc_q;
        end
    end

    assign instr_valid = head_valid;
    assign instr       = head_valid ? queue_instr_q[head_q] : '0;
    assign instr_pc    = head_valid ? queue_pc_q[head_q] : '0;
    assign fetch_fault = fault_q;

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    // Saturating counters for delivered instructions and starved RUN cycles
    always_ff @(posedge CLK) begin
        if (reset) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (pop && (fetched_q != 32'hFFFF_FFFF)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if ((state_q == ST_RUN) && instr_ready && !head_valid && (bubbles_q != 32'hFFFF_FFFF)) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule
